// File: rtl/memory_access_unit.sv
// Memory access unit: word RAM plus a memory-mapped byte I/O port, load results returned on the CDB.
// Optional RX byte FIFO on the input stream is enabled by defining MAU_IO_FIFO_EN.
package fcpu_pkg;
   localparam int INSTR_W = 5;
   // Only the store-class opcodes are named here; every other code is treated as a load.
   localparam logic [INSTR_W-1:0] I_STORE   = 5'h08;
   localparam logic [INSTR_W-1:0] I_STOREB  = 5'h09;
   localparam logic [INSTR_W-1:0] I_STORER  = 5'h0A;
   localparam logic [INSTR_W-1:0] I_STOREF  = 5'h0B;
   localparam logic [INSTR_W-1:0] I_STOREBF = 5'h0C;
   localparam logic [INSTR_W-1:0] I_STORERF = 5'h0D;
   localparam logic [INSTR_W-1:0] I_OUTPUT  = 5'h0E;
endpackage

module memory_access_unit
   import fcpu_pkg::*;
#(
   parameter int                DATA_W        = 32,
   parameter int                RSV_W         = 1,
   parameter int                MEM_DEPTH     = 1024,
   parameter logic [DATA_W-1:0] IO_ADDR       = '1,
   parameter int                IO_FIFO_DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [RSV_W-1:0]          rsv_id,
   input  logic                      valid,
   input  logic [DATA_W-1:0]         data,
   input  logic [DATA_W-1:0]         address,
   input  logic [INSTR_W-1:0]        opcode,
   output logic                      ready,
   output logic [7:0]                io_o_data,
   output logic                      io_o_valid,
   input  logic                      io_o_ready,
   input  logic [7:0]                io_i_data,
   input  logic                      io_i_valid,
   output logic                      io_i_ready,
   output logic [RSV_W+DATA_W-1:0]   o_cdb,
   output logic                      o_cdb_valid,
   input  logic                      o_cdb_ready
);
   localparam int AW = $clog2(MEM_DEPTH);

   if (MEM_DEPTH < 2 || (MEM_DEPTH & (MEM_DEPTH - 1)) != 0) begin : g_bad_mem_depth
      $error("MEM_DEPTH must be a power of 2");
   end
   if (IO_FIFO_DEPTH < 2 || (IO_FIFO_DEPTH & (IO_FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
      $error("IO_FIFO_DEPTH must be a power of 2 and at least 2");
   end

   typedef enum logic [1:0] {IDLE, MEM_RD, CDB_WAIT} state_t;

   function automatic logic is_store_op(input logic [INSTR_W-1:0] op);
      case (op)
         I_STORE, I_STOREB, I_STORER, I_STOREF, I_STOREBF, I_STORERF, I_OUTPUT: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   state_t              state;
   logic [DATA_W-1:0]   mem [MEM_DEPTH];
   logic [AW-1:0]       rd_idx_p0;
   logic [RSV_W-1:0]    tag_p0;
   logic                store;
   logic                io_sel;
   logic                rx_avail;
   logic                accept;
   logic [AW-1:0]       ram_idx;
   logic [7:0]          rx_byte;

   assign store   = is_store_op(opcode);
   assign io_sel  = (address == IO_ADDR);
   assign ram_idx = address[AW-1:0];

   always_comb begin
      ready = 1'b0;
      if (state == IDLE) begin
         if (store) ready = io_sel ? (!io_o_valid || io_o_ready) : 1'b1;
         else       ready = io_sel ? rx_avail : 1'b1;
      end
   end

   assign accept = valid && ready;

   // Accept stage: RAM write and capture of the read index/tag for a RAM load
   always_ff @(posedge clk) begin
      if (accept && store && !io_sel) mem[ram_idx] <= data;
      if (accept && !store && !io_sel) begin
         rd_idx_p0 <= ram_idx;
         tag_p0    <= rsv_id;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         o_cdb_valid <= 1'b0;
         o_cdb       <= '0;
         io_o_valid  <= 1'b0;
         io_o_data   <= '0;
      end else begin
         // A new I/O store may replace a byte that is handshaking in the same cycle
         if (accept && store && io_sel) begin
            io_o_data  <= data[7:0];
            io_o_valid <= 1'b1;
         end else if (io_o_valid && io_o_ready) begin
            io_o_valid <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (accept && !store) begin
                  if (io_sel) begin
                     o_cdb       <= {rsv_id, {(DATA_W-8){1'b0}}, rx_byte};
                     o_cdb_valid <= 1'b1;
                     state       <= CDB_WAIT;
                  end else begin
                     state <= MEM_RD;
                  end
               end
            end
            // Read stage: RAM word onto the CDB register
            MEM_RD: begin
               o_cdb       <= {tag_p0, mem[rd_idx_p0]};
               o_cdb_valid <= 1'b1;
               state       <= CDB_WAIT;
            end
            CDB_WAIT: begin
               if (o_cdb_ready) begin
                  o_cdb_valid <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef MAU_IO_FIFO_EN
   localparam int PW = $clog2(IO_FIFO_DEPTH);
   localparam logic [PW:0] FIFO_FULL = (PW+1)'(IO_FIFO_DEPTH);

   logic [7:0]    fifo_mem [IO_FIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   count;
   logic          push;
   logic          pop;

   assign io_i_ready = (count != FIFO_FULL);
   assign push       = io_i_valid && io_i_ready;
   assign pop        = accept && !store && io_sel;
   assign rx_avail   = (count != '0);
   assign rx_byte    = fifo_mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= io_i_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: ;
         endcase
      end
   end
`else
   // Without a buffer the RX byte is taken straight off the stream in the accept cycle
   assign io_i_ready = (state == IDLE) && valid && !store && io_sel;
   assign rx_avail   = io_i_valid;
   assign rx_byte    = io_i_data;
`endif

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed bench for memory_access_unit: RAM store/load, I/O store backpressure, RX path, CDB stall, reset abort.
module tb_memory_access_unit;
   import fcpu_pkg::*;

   localparam logic [31:0]        IO    = 32'hFFFF_FFFF;
   localparam logic [INSTR_W-1:0] OP_LD = 5'h00;
   localparam logic [INSTR_W-1:0] OP_IN = 5'h0F;

   logic        clk = 1'b0;
   logic        rst;
   logic [0:0]  rsv_id;
   logic        valid;
   logic [31:0] data;
   logic [31:0] address;
   logic [INSTR_W-1:0] opcode;
   logic        ready;
   logic [7:0]  io_o_data;
   logic        io_o_valid;
   logic        io_o_ready;
   logic [7:0]  io_i_data;
   logic        io_i_valid;
   logic        io_i_ready;
   logic [32:0] o_cdb;
   logic        o_cdb_valid;
   logic        o_cdb_ready;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   memory_access_unit #(
      .DATA_W(32), .RSV_W(1), .MEM_DEPTH(1024), .IO_ADDR(32'hFFFF_FFFF), .IO_FIFO_DEPTH(4)
   ) dut (
      .clk(clk), .rst(rst), .rsv_id(rsv_id), .valid(valid), .data(data), .address(address),
      .opcode(opcode), .ready(ready), .io_o_data(io_o_data), .io_o_valid(io_o_valid),
      .io_o_ready(io_o_ready), .io_i_data(io_i_data), .io_i_valid(io_i_valid),
      .io_i_ready(io_i_ready), .o_cdb(o_cdb), .o_cdb_valid(o_cdb_valid), .o_cdb_ready(o_cdb_ready)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not reach its end");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; valid = 1'b0; data = '0; address = 32'd5; opcode = OP_LD; rsv_id = 1'b0;
      io_o_ready = 1'b0; io_i_data = '0; io_i_valid = 1'b0; o_cdb_ready = 1'b0;
      tick(); tick();
      rst = 1'b0; #1;
      check("rst_cdb_valid", o_cdb_valid, 0);
      check("rst_cdb", o_cdb, 0);
      check("rst_io_o_valid", io_o_valid, 0);
      check("rst_io_o_data", io_o_data, 0);
      check("rst_ready_idle", ready, 1);
`ifdef MAU_IO_FIFO_EN
      check("rst_rx_not_full", io_i_ready, 1);
      opcode = OP_IN; address = IO; #1;
      check("rst_rx_empty", ready, 0);
`else
      check("rst_io_i_ready", io_i_ready, 0);
`endif

      // RAM store then load of the same word in the next cycle
      valid = 1'b1; opcode = I_STOREB; address = 32'd5; data = 32'h1234_5678; #1;
      check("st_ready", ready, 1);
      tick();
      opcode = OP_LD; rsv_id = 1'b1; #1;
      check("ld_ready", ready, 1);
      tick();
      valid = 1'b0; #1;
      check("ld_mem_rd_ready", ready, 0);
      check("ld_lat1_valid", o_cdb_valid, 0);
      tick();
      check("ld_lat2_valid", o_cdb_valid, 1);
      check("ld_data", o_cdb, 33'h1_1234_5678);
      o_cdb_ready = 1'b1;
      tick();
      check("ld_done", o_cdb_valid, 0);

      // Upper address bits alias onto the same RAM word
      valid = 1'b1; opcode = I_STORE; address = 32'h0000_0407; data = 32'hA5A5_0F0F; rsv_id = 1'b0;
      tick();
      opcode = OP_LD; address = 32'd7;
      tick();
      valid = 1'b0;
      tick();
      check("alias_valid", o_cdb_valid, 1);
      check("alias_data", o_cdb, 33'h0_A5A5_0F0F);
      tick();

      // CDB stall for 5 cycles with a store waiting behind it
      o_cdb_ready = 1'b0; valid = 1'b1; opcode = OP_LD; address = 32'd5; rsv_id = 1'b0;
      tick();
      opcode = I_STORER; address = 32'd9; data = 32'h0000_0099;
      tick();
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", o_cdb_valid, 1);
         check("bp_data", o_cdb, 33'h0_1234_5678);
         check("bp_ready", ready, 0);
         if (i < 4) tick();
      end
      o_cdb_ready = 1'b1; #1;
      check("bp_hs_ready", ready, 0);
      tick();
      check("bp_after_valid", o_cdb_valid, 0);
      check("bp_after_ready", ready, 1);
      tick();
      opcode = OP_LD; address = 32'd9;
      tick();
      valid = 1'b0;
      tick();
      check("bp_store_data", o_cdb, 33'h0_0000_0099);
      tick();

      // I/O store held under TX backpressure
      io_o_ready = 1'b0; valid = 1'b1; opcode = I_OUTPUT; address = IO; data = 32'h0000_01A4; #1;
      check("out_ready", ready, 1);
      tick();
      data = 32'h0000_0155;
      for (int i = 0; i < 3; i++) begin
         check("out_valid", io_o_valid, 1);
         check("out_data", io_o_data, 8'hA4);
         check("out2_blocked", ready, 0);
         tick();
      end
      io_o_ready = 1'b1; #1;
      check("out2_ready", ready, 1);
      tick();
      valid = 1'b0;
      check("out2_valid", io_o_valid, 1);
      check("out2_data", io_o_data, 8'h55);
      tick();
      check("out_drained", io_o_valid, 0);
      io_o_ready = 1'b0;

`ifdef MAU_IO_FIFO_EN
      // RX FIFO fill past capacity, then drain in order
      o_cdb_ready = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         io_i_valid = 1'b1; io_i_data = 8'(i); #1;
         check("rx_in_ready", io_i_ready, (i <= 4) ? 64'd1 : 64'd0);
         if (i < 5) tick();
      end
      valid = 1'b1; opcode = OP_IN; address = IO;
      for (int j = 1; j <= 5; j++) begin
         rsv_id = 1'(j & 1); #1;
         check("rx_ld_ready", ready, 1);
         tick();
         check("rx_ld_valid", o_cdb_valid, 1);
         check("rx_ld_data", o_cdb, {31'd0, 1'(j & 1), 24'd0, 8'(j)});
         if (j == 1) check("rx_refill_ready", io_i_ready, 1);
         tick();
         if (j == 1) io_i_valid = 1'b0;
      end
      check("rx_empty_ready", ready, 0);

      // Push and pop in the same cycle leave the count unchanged
      valid = 1'b0; io_i_valid = 1'b1; io_i_data = 8'h66;
      tick();
      io_i_data = 8'h77; valid = 1'b1; rsv_id = 1'b0; #1;
      check("pp_ready", ready, 1);
      tick();
      io_i_valid = 1'b0;
      check("pp_data1", o_cdb, 33'h0_0000_0066);
      tick();
      check("pp_one_left", ready, 1);
      tick();
      check("pp_data2", o_cdb, 33'h0_0000_0077);
      tick();
      check("pp_empty", ready, 0);
      valid = 1'b0;

      io_i_valid = 1'b1; io_i_data = 8'hEE;
      tick();
      io_i_valid = 1'b0;
`else
      // Direct RX capture without a buffer
      o_cdb_ready = 1'b0; valid = 1'b1; opcode = OP_IN; address = IO; rsv_id = 1'b1;
      io_i_valid = 1'b0; #1;
      check("dir_ready_nodata", ready, 0);
      check("dir_io_i_ready", io_i_ready, 1);
      io_i_valid = 1'b1; io_i_data = 8'hC3; #1;
      check("dir_ready", ready, 1);
      tick();
      io_i_valid = 1'b0; io_i_data = 8'h00; #1;
      check("dir_valid", o_cdb_valid, 1);
      check("dir_data", o_cdb, 33'h1_0000_00C3);
      check("dir_io_i_ready_busy", io_i_ready, 0);
      valid = 1'b0; o_cdb_ready = 1'b1;
      tick();
      check("dir_done", o_cdb_valid, 0);
      valid = 1'b1; opcode = OP_LD; address = 32'd5; #1;
      check("dir_ram_ld_no_rx", io_i_ready, 0);
      valid = 1'b0;
`endif

      // Reset while a RAM load is in MEM_RD
      o_cdb_ready = 1'b0; valid = 1'b1; opcode = OP_LD; address = 32'd5; rsv_id = 1'b1;
      tick();
      valid = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rr_valid", o_cdb_valid, 0);
      check("rr_cdb", o_cdb, 0);
      tick(); tick();
      check("rr_valid_later", o_cdb_valid, 0);
      check("rr_idle", ready, 1);
`ifdef MAU_IO_FIFO_EN
      opcode = OP_IN; address = IO; #1;
      check("rr_rx_empty", ready, 0);
`endif
      o_cdb_ready = 1'b1; valid = 1'b1; opcode = OP_LD; address = 32'd5; rsv_id = 1'b0;
      tick();
      valid = 1'b0;
      tick();
      check("rr_ram_kept", o_cdb, 33'h0_1234_5678);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/memory_access_unit.md
MEMORY_ACCESS_UNIT -- requirements
Module: memory_access_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, core data width.
REQ-002 SHALL have parameter RSV_W, default 1, reservation-station tag width.
REQ-003 SHALL have parameter MEM_DEPTH, default 1024, data RAM words (power of 2).
REQ-004 SHALL have parameter IO_ADDR, default all-ones (DATA_W bits), memory-mapped I/O address.
REQ-005 SHALL have parameter IO_FIFO_DEPTH, default 4, RX byte FIFO entries (power of 2, >=2).
REQ-006 SHALL have ports: clk  in  1  clock; single clock domain, all logic on rising edge.
REQ-007 SHALL have ports: rst  in  1  synchronous reset, active-high.
REQ-008 SHALL have ports: rsv_id  in  RSV_W  tag of the issuing request.
REQ-009 SHALL have ports: valid  in  1  request present.
REQ-010 SHALL have ports: data  in  DATA_W  store data.
REQ-011 SHALL have ports: address  in  DATA_W  word address.
REQ-012 SHALL have ports: opcode  in  INSTR_W  fcpu_pkg opcode.
REQ-013 SHALL have ports: ready  out  1  request accepted this cycle when valid&&ready.
REQ-014 SHALL have ports: io_o_data  out  8, io_o_valid  out  1, io_o_ready  in  1  TX byte stream.
REQ-015 SHALL have ports: io_i_data  in  8, io_i_valid  in  1, io_i_ready  out  1  RX byte stream.
REQ-016 SHALL have ports: o_cdb  out  RSV_W+DATA_W  {tag, result}, o_cdb_valid  out  1, o_cdb_ready  in  1.

Function
REQ-017 SHALL classify I_STORE, I_STOREB, I_STORER, I_STOREF, I_STOREBF, I_STORERF, I_OUTPUT as stores; all other opcodes as loads.
REQ-018 SHALL route address==IO_ADDR to I/O; otherwise to RAM index address[clog2(MEM_DEPTH)-1:0]; upper bits ignored.
REQ-019 SHALL implement FSM IDLE, MEM_RD, CDB_WAIT; ready SHALL be 0 outside IDLE.
REQ-020 In IDLE, ready SHALL be: RAM store 1; I/O store (!io_o_valid || io_o_ready); RAM load 1; I/O load RX not empty.
REQ-021 RAM store SHALL write data in the accept cycle; no CDB output; FSM stays IDLE.
REQ-022 I/O store SHALL register data[7:0] to io_o_data with io_o_valid=1 the next cycle, held stable until io_o_ready.
REQ-023 RAM load SHALL go IDLE->MEM_RD->CDB_WAIT; o_cdb_valid asserts 2 cycles after accept with {rsv_id, ram word}.
REQ-024 I/O load SHALL pop one RX byte at accept, go IDLE->CDB_WAIT; o_cdb_valid asserts 1 cycle after accept, result zero-extended to DATA_W.
REQ-025 In CDB_WAIT o_cdb/o_cdb_valid SHALL stay stable until o_cdb_ready; on handshake return to IDLE (new request acceptable next cycle).
REQ-026 A load to an address stored in the immediately preceding cycle SHALL return the new data.
REQ-027 RX buffer: io_i_ready = !full; push on io_i_valid&&io_i_ready; byte order preserved; pointer wrap modulo IO_FIFO_DEPTH.
REQ-028 Simultaneous RX push and pop SHALL keep count unchanged; pop when empty or push when full SHALL never occur.

Reset
REQ-029 On rst: FSM IDLE, ready 0 only as derived from state, o_cdb_valid 0, o_cdb 0, io_o_valid 0, io_o_data 0, RX FIFO empty; RAM contents not cleared.
REQ-030 rst during MEM_RD/CDB_WAIT SHALL discard the pending result; no o_cdb_valid after reset until a new load is accepted.

Configuration
REQ-031 Macro MAU_IO_FIFO_EN: defined -> RX FIFO per REQ-027/028; undefined -> no FIFO, io_i_ready = (IDLE && valid && I/O load), I/O load ready = io_i_valid, byte captured directly at accept; all latencies unchanged.

Verification
REQ-032 RAM store 0x12345678 @5, then load @5 tag 1 -> ready 1 both, o_cdb_valid 2 cycles after load accept, o_cdb={1,0x12345678}.
REQ-033 I/O store data 0x1A4 while io_o_ready=0 for 3 cycles -> io_o_data 0xA4 held valid 3 cycles, second I/O store ready=0 until handshake.
REQ-034 Push bytes 0x01..0x05 with FIFO depth 4, no loads -> io_i_ready 0 after 4th; 4 I/O loads return 0x01..0x04 in order, then 0x05 accepted.
REQ-035 RAM load with o_cdb_ready=0 for 5 cycles -> o_cdb stable, ready 0, new request accepted cycle after handshake.
REQ-036 rst asserted in MEM_RD -> o_cdb_valid stays 0, FSM IDLE, RX FIFO empty, RAM @5 still 0x12345678.
